// File: rtl/mem_dp_be.sv
// mem_dp_be: dual-port RAM with byte enables, 1- or 2-cycle read pipeline, collision policy and clear sweep
// Ports: clk, rst_n (async active-low) | wen, waddr, wdata, wbe write port | ren, raddr read port
//        clr starts a zeroing sweep | rdata, rvalid read result | busy high while sweeping
module mem_dp_be #(
    parameter int WIDTH      = 8,
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wbe,
    input  logic                  ren,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  clr,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  busy
);
    localparam int NB = WIDTH / 8;
    // one extra bit so the range test stays meaningful when SIZE is a power of two
    localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [RD_LAT-1:0]     vld_q, vld_d;
    logic [WIDTH-1:0]      dat_q [RD_LAT];
    logic [WIDTH-1:0]      dat_d [RD_LAT];
    logic [WIDTH-1:0]      mem [SIZE];
    logic                  w_in, r_in, wr_acc, rd_acc;
    logic [WIDTH-1:0]      w_old, w_new, r_word;

    assign w_in   = {1'b0, waddr} < SIZE_W;
    assign r_in   = {1'b0, raddr} < SIZE_W;
    assign wr_acc = wen && !busy && w_in;
    assign rd_acc = ren && !busy;
    assign w_old  = w_in ? mem[waddr] : '0;

    always_comb begin
        w_new = w_old;
        for (int i = 0; i < NB; i++) w_new[8*i +: 8] = wbe[i] ? wdata[8*i +: 8] : w_old[8*i +: 8];
    end

    // memory is read combinationally before the edge, so read-first falls out naturally;
    // write-first bypasses the merged word on an address match
    assign r_word = !r_in ? '0 :
                    (WR_MODE == 1 && wr_acc && waddr == raddr) ? w_new : mem[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            state_d = cnt_q == LAST ? IDLE : CLEAR;
            cnt_d   = cnt_q == LAST ? '0 : cnt_q + ADDR_WIDTH'(1);
        end else if (clr) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
    end

    always_comb busy = state_q == CLEAR;

    always_ff @(posedge clk) begin
        if (busy) mem[cnt_q] <= '0;
        else if (wr_acc) mem[waddr] <= w_new;
    end

    // each stage holds its data when nothing new arrives, so rdata keeps its last value
    always_comb begin
        vld_d    = vld_q;
        dat_d    = dat_q;
        vld_d[0] = rd_acc;
        dat_d[0] = rd_acc ? r_word : dat_q[0];
        for (int k = 1; k < RD_LAT; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) dat_q[k] <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign rdata  = dat_q[RD_LAT-1];
    assign rvalid = vld_q[RD_LAT-1];
endmodule

// File: tb/tb_mem_dp_be.sv
// tb_mem_dp_be: checks two mem_dp_be configurations against a queue-based reference model
module tb_mem_dp_be;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen, ren, clr;
    logic [4:0]  waddr, raddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, busy0, busy1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_dp_be #(.WIDTH(32), .SIZE(32), .RD_LAT(2), .WR_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .clr(clr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0));

    mem_dp_be #(.WIDTH(32), .SIZE(32), .RD_LAT(1), .WR_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .clr(clr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

    function automatic void check(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    typedef struct {int due; logic [31:0] d;} exp_t;
    exp_t        q0[$], q1[$];
    logic [31:0] m [32];
    int          cyc = 0;
    int          sw = 32;

    // reference: the array, a count of sweep cycles still owed, and per-instance result queues
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw = 32;
            q0.delete();
            q1.delete();
        end else begin
            logic [31:0] old, nw;
            cyc++;
            if (sw > 0) begin
                m[32-sw] = 0;
                sw--;
            end else begin
                old = m[raddr];
                nw  = merge(m[waddr], wdata, wbe);
                if (ren) begin
                    q0.push_back('{cyc + 1, old});
                    q1.push_back('{cyc, (wen && waddr == raddr) ? nw : old});
                end
                if (wen) m[waddr] = nw;
                if (clr) sw = 32;
            end
        end
    end

    logic [31:0] last0 = 0, last1 = 0;
    exp_t        tmp;
    logic        e0, e1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last0 = 0;
            last1 = 0;
        end
        e0 = q0.size() > 0 && q0[0].due == cyc;
        e1 = q1.size() > 0 && q1[0].due == cyc;
        if (e0) begin tmp = q0.pop_front(); last0 = tmp.d; end
        if (e1) begin tmp = q1.pop_front(); last1 = tmp.d; end
        check("u0.rvalid", rvalid0, e0);
        check("u0.rdata", rdata0, last0);
        check("u1.rvalid", rvalid1, e1);
        check("u1.rdata", rdata1, last1);
        check("u0.busy", busy0, sw > 0);
        check("u1.busy", busy1, sw > 0);
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wen = 1; waddr = a; wdata = d; wbe = be;
        @(negedge clk);
        wen = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d0, output logic [31:0] d1,
                      output int l0, output int l1);
        ren = 1; raddr = a; l0 = -1; l1 = -1; d0 = 'x; d1 = 'x;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            ren = 0; wen = 0;
            if (rvalid0 && l0 < 0) begin l0 = k; d0 = rdata0; end
            if (rvalid1 && l1 < 0) begin l1 = k; d1 = rdata1; end
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_all(output int nv, output int nz);
        nv = 0; nz = 0;
        for (int a = 0; a < 34; a++) begin
            ren = a < 32; raddr = a[4:0];
            @(negedge clk);
            if (rvalid0) begin nv++; if (rdata0 != 0) nz++; end
        end
        ren = 0;
    endtask

    typedef struct {logic [4:0] a; logic [31:0] d; logic [3:0] be; logic [31:0] want;} vec_t;
    vec_t tbl[6];

    initial begin
        int n, nv, nz, l0, l1;
        logic [31:0] d0, d1;
        tbl[0] = '{5'd5,  32'h0000_00A5, 4'b0001, 32'h0000_00A5};
        tbl[1] = '{5'd7,  32'h1122_3344, 4'b1111, 32'h1122_3344};
        tbl[2] = '{5'd7,  32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD};
        tbl[3] = '{5'd7,  32'hFFFF_FFFF, 4'b0000, 32'h11BB_33DD};
        tbl[4] = '{5'd31, 32'hDEAD_BEEF, 4'b1010, 32'hDE00_BE00};
        tbl[5] = '{5'd0,  32'h1234_5678, 4'b1100, 32'h1234_0000};
        wen = 0; ren = 0; clr = 0; waddr = 0; raddr = 0; wdata = 0; wbe = 0;

        repeat (3) @(negedge clk);
        check("rst.rvalid", rvalid0, 0);
        check("rst.rdata", rdata0, 0);
        check("rst.busy", busy0, 1);
        #2 rst_n = 1;
        count_busy(n);
        check("rst.busy_len", n, 32);
        read_all(nv, nz);
        check("rst.read_cnt", nv, 32);
        check("rst.nonzero", nz, 0);

        foreach (tbl[i]) begin
            wr(tbl[i].a, tbl[i].d, tbl[i].be);
            rd(tbl[i].a, d0, d1, l0, l1);
            check("tbl.u0.data", d0, tbl[i].want);
            check("tbl.u1.data", d1, tbl[i].want);
            check("tbl.u0.lat", l0, 2);
            check("tbl.u1.lat", l1, 1);
        end

        wr(5'd3, 32'h10, 4'hF);
        wen = 1; waddr = 3; wdata = 32'h20; wbe = 4'hF;
        rd(5'd3, d0, d1, l0, l1);
        check("coll.read_first", d0, 32'h10);
        check("coll.write_first", d1, 32'h20);
        rd(5'd3, d0, d1, l0, l1);
        check("coll.after.u0", d0, 32'h20);
        check("coll.after.u1", d1, 32'h20);

        for (int a = 0; a < 32; a++) wr(a[4:0], 32'hFF, 4'hF);
        clr = 1;
        @(negedge clk);
        clr = 0;
        nv = 0;
        for (int k = 0; k < 34; k++) begin
            wen = k < 32; ren = k < 32; clr = k < 32;
            waddr = 5'($urandom); raddr = 5'($urandom); wdata = $urandom; wbe = 4'hF;
            @(negedge clk);
            if (rvalid0 || rvalid1) nv++;
        end
        wen = 0; ren = 0; clr = 0;
        check("clr.no_rvalid", nv, 0);
        check("clr.idle", busy0, 0);
        read_all(nv, nz);
        check("clr.read_cnt", nv, 32);
        check("clr.nonzero", nz, 0);

        ren = 1; raddr = 7;
        @(negedge clk);
        ren = 0;
        #2 rst_n = 0;
        #1 check("mr.u1.rvalid", rvalid1, 0);
        check("mr.u0.rvalid", rvalid0, 0);
        check("mr.busy", busy0, 1);
        @(negedge clk);
        check("mr.u0.late", rvalid0, 0);
        #2 rst_n = 1;
        count_busy(n);
        check("mr.busy_len", n, 32);

        wr(5'd7, 32'hCAFE_F00D, 4'hF);
        clr = 1; ren = 1; raddr = 7;
        @(negedge clk);
        clr = 0; ren = 0;
        check("ms.pre.u1.rvalid", rvalid1, 1);
        check("ms.pre.u1.rdata", rdata1, 32'hCAFE_F00D);
        @(negedge clk);
        check("ms.pre.u0.rvalid", rvalid0, 1);
        check("ms.pre.u0.rdata", rdata0, 32'hCAFE_F00D);
        repeat (9) @(negedge clk);
        check("ms.busy", busy0, 1);
        #2 rst_n = 0;
        #1 check("ms.rvalid", rvalid0, 0);
        @(negedge clk);
        #2 rst_n = 1;
        count_busy(n);
        check("ms.busy_len", n, 32);

        for (int k = 0; k < 600; k++) begin
            wen = 1'($urandom); ren = 1'($urandom); clr = $urandom_range(0, 99) == 0;
            waddr = 5'($urandom); raddr = 5'($urandom); wdata = $urandom; wbe = 4'($urandom);
            @(negedge clk);
        end
        wen = 0; ren = 0; clr = 0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_dp_be.md
MEM_DP_BE -- requirements
Module: mem_dp_be

Interface
- Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL have parameter WIDTH, default 8, data word width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter SIZE, default 32, number of words.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(SIZE), address width.
REQ-004 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-005 The block SHALL have parameter WR_MODE, default 0, collision policy: 0 = read-first, 1 = write-first.
- Ports (one per line: name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port wen, input, 1 bit, write request.
REQ-009 The block SHALL have port waddr, input, ADDR_WIDTH bits, write address.
REQ-010 The block SHALL have port wdata, input, WIDTH bits, write data.
REQ-011 The block SHALL have port wbe, input, WIDTH/8 bits, byte enables; bit i covers wdata[8i+7:8i].
REQ-012 The block SHALL have port ren, input, 1 bit, read request.
REQ-013 The block SHALL have port raddr, input, ADDR_WIDTH bits, read address.
REQ-014 The block SHALL have port clr, input, 1 bit, request to clear the whole array.
REQ-015 The block SHALL have port rdata, output, WIDTH bits, read data.
REQ-016 The block SHALL have port rvalid, output, 1 bit, one-cycle strobe qualifying rdata.
REQ-017 The block SHALL have port busy, output, 1 bit, high while the clear sweep runs.

Function
REQ-018 Separate read and write ports SHALL operate in the same cycle; each accepts one access per cycle.
REQ-019 A write SHALL be accepted at an edge where wen=1 and busy=0; only bytes with wbe[i]=1 are updated. wbe=0 leaves the word unchanged.
REQ-020 A read SHALL be accepted at an edge where ren=1 and busy=0; rdata and rvalid=1 appear RD_LAT cycles later, and rvalid=1 lasts one cycle per accepted read.
REQ-021 Back-to-back reads SHALL give one result per cycle, fully pipelined, in request order.
REQ-022 rdata SHALL hold its last value when rvalid=0.
REQ-023 When a read and a write to the same address are accepted at the same edge: with WR_MODE=0, rdata SHALL return the pre-write word; with WR_MODE=1, rdata SHALL return the word after the byte-enable merge.
REQ-024 Out-of-range addresses (≥SIZE, when SIZE is not a power of two) SHALL be ignored for writes and SHALL return 0 for reads, with rvalid still asserted.
REQ-025 The controller SHALL have exactly two states, IDLE and CLEAR.
REQ-026 IDLE -> CLEAR SHALL happen on clr=1 sampled in IDLE.
REQ-027 In CLEAR, the block SHALL write 0 to addresses 0..SIZE-1, one per cycle, using an internal counter.
REQ-028 After writing address SIZE-1, the state SHALL return to IDLE; the sweep takes exactly SIZE cycles.
REQ-029 busy SHALL equal 1 exactly while the state is CLEAR.
REQ-030 While busy=1, wen, ren and clr SHALL be ignored; no access is queued.
REQ-031 Reads accepted before clr SHALL still complete at their scheduled cycles with pre-clear data.
REQ-032 In WR_MODE=1, a read accepted on the cycle clr is sampled SHALL return pre-clear data.

Reset
REQ-033 When rst_n=0, the block SHALL immediately force rdata=0, rvalid=0, the read pipeline empty, the counter to 0 and the state to CLEAR (busy=1).
REQ-034 After rst_n rises, the block SHALL run the full SIZE-cycle sweep, then enter IDLE.
REQ-035 Array contents SHALL be defined only after the first sweep completes.
REQ-036 Reset asserted mid-sweep or mid-read SHALL discard in-flight reads and restart the sweep from address 0.

Verification
REQ-037 Reset release: rst_n low for 3 cycles, then high -> busy=1 for exactly 32 cycles, then 0; a read of every address then returns 0x00.
REQ-038 Latency: default parameters with RD_LAT=2; write 0xA5 to addr 5; read addr 5 at cycle N -> rvalid=1 at N+2 only, rdata=0xA5.
REQ-039 Byte enables: WIDTH=32; write 0x11223344 with wbe=4'b1111, then 0xAABBCCDD with wbe=4'b0101 to the same address -> read returns 0x11BB33DD.
REQ-040 Collision: addr 3 holds 0x10; same-edge write 0x20 and read of addr 3 -> rdata=0x10 with WR_MODE=0 and 0x20 with WR_MODE=1; a following read returns 0x20 in both modes.
REQ-041 Clear during traffic: fill addrs 0-31 with 0xFF, pulse clr, drive wen/ren every cycle for 32 cycles -> no rvalid and no writes during busy; afterwards all addresses read 0x00.
REQ-042 Mid-sweep reset: assert rst_n=0 at sweep count 10 for 1 cycle -> rvalid=0 immediately; busy remains 1 for a full 32 cycles after release.
